// File: rtl/mem_access_pkg.sv
// Shared constants for the MEM stage: memory op codes, register defaults and FSM states.
// Helper functions classify op codes and build replicated store data.
package mem_access_pkg;

    localparam logic [7:0] OpLb  = 8'b1110_0000;
    localparam logic [7:0] OpLbu = 8'b1110_0100;
    localparam logic [7:0] OpLh  = 8'b1110_0001;
    localparam logic [7:0] OpLhu = 8'b1110_0101;
    localparam logic [7:0] OpLw  = 8'b1110_0011;
    localparam logic [7:0] OpSb  = 8'b1110_1000;
    localparam logic [7:0] OpSh  = 8'b1110_1001;
    localparam logic [7:0] OpSw  = 8'b1110_1011;

    localparam logic [4:0]  NOPRegAddr   = 5'b00000;
    localparam logic [31:0] ZeroWord     = 32'h0000_0000;
    localparam logic        WriteEnable  = 1'b1;
    localparam logic        WriteDisable = 1'b0;

    typedef enum logic [1:0] {StIdle, StBusy, StDone} mem_state_e;

    function automatic logic is_load_op(input logic [7:0] op);
        case (op)
            OpLb, OpLbu, OpLh, OpLhu, OpLw: return 1'b1;
            default:                        return 1'b0;
        endcase
    endfunction

    function automatic logic is_store_op(input logic [7:0] op);
        case (op)
            OpSb, OpSh, OpSw: return 1'b1;
            default:          return 1'b0;
        endcase
    endfunction

    // Stores replicate the operand across every lane; bus_sel picks the live bytes.
    function automatic logic [31:0] store_data(input logic [7:0] op, input logic [31:0] reg2);
        case (op)
            OpSb:    return {4{reg2[7:0]}};
            OpSh:    return {2{reg2[15:0]}};
            default: return reg2;
        endcase
    endfunction

endpackage

// File: rtl/mem_load_align.sv
// Big-endian byte-lane select and load-data extraction for the MEM stage.
// Purely combinational; misaligned low address bits are ignored for halfword/word ops.
module mem_load_align
    import mem_access_pkg::*;
(
    input  logic [7:0]  aluop,
    input  logic [1:0]  addr,
    input  logic [31:0] rdata,
    output logic [3:0]  sel,
    output logic [31:0] data
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;
    logic [3:0]  byte_sel;
    logic [3:0]  half_sel;

    always_comb begin
        byte_lane = rdata[31:24];
        byte_sel  = 4'b1000;
        unique case (addr)
            2'b00: begin byte_lane = rdata[31:24]; byte_sel = 4'b1000; end
            2'b01: begin byte_lane = rdata[23:16]; byte_sel = 4'b0100; end
            2'b10: begin byte_lane = rdata[15:8];  byte_sel = 4'b0010; end
            2'b11: begin byte_lane = rdata[7:0];   byte_sel = 4'b0001; end
            default: ;
        endcase
        half_lane = addr[1] ? rdata[15:0] : rdata[31:16];
        half_sel  = addr[1] ? 4'b0011 : 4'b1100;
    end

    always_comb begin
        sel  = 4'b0000;
        data = ZeroWord;
        case (aluop)
            OpLb:        begin sel = byte_sel; data = {{24{byte_lane[7]}}, byte_lane}; end
            OpLbu:       begin sel = byte_sel; data = {24'h0, byte_lane}; end
            OpSb:        begin sel = byte_sel; data = {24'h0, byte_lane}; end
            OpLh:        begin sel = half_sel; data = {{16{half_lane[15]}}, half_lane}; end
            OpLhu, OpSh: begin sel = half_sel; data = {16'h0, half_lane}; end
            OpLw, OpSw:  begin sel = 4'b1111;  data = rdata; end
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_access.sv
// MEM pipeline stage: issues one registered bus access per load/store and stalls until ack.
// Results pass straight through for non-memory ops; loads return latched, aligned data.
module mem_access
    import mem_access_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  ex_wd,
    input  logic        ex_wreg,
    input  logic [31:0] ex_wdata,
    input  logic        ex_whilo,
    input  logic [31:0] ex_hi,
    input  logic [31:0] ex_lo,
    input  logic [7:0]  ex_aluop,
    input  logic [31:0] ex_mem_addr,
    input  logic [31:0] ex_reg2,
    input  logic [5:0]  stall,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata,
    output logic [4:0]  mem_wd,
    output logic        mem_wreg,
    output logic [31:0] mem_wdata,
    output logic        mem_whilo,
    output logic [31:0] mem_hi,
    output logic [31:0] mem_lo,
    output logic        stallreq,
    output logic        bus_stb,
    output logic        bus_we,
    output logic [3:0]  bus_sel,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata
);

    mem_state_e  state_q, state_d;
    logic        bus_stb_q, bus_stb_d;
    logic        bus_we_q, bus_we_d;
    logic [3:0]  bus_sel_q, bus_sel_d;
    logic [31:0] bus_addr_q, bus_addr_d;
    logic [31:0] bus_wdata_q, bus_wdata_d;
    logic [31:0] data_q, data_d;

    logic        load_op, store_op, mem_op;
    logic [3:0]  lane_sel;
    logic [31:0] load_data;
    logic        unused_stall;

    assign load_op      = is_load_op(ex_aluop);
    assign store_op     = is_store_op(ex_aluop);
    assign mem_op       = load_op | store_op;
    assign unused_stall = ^{stall[5], stall[3:0]};

    // ex_* is held by the pipeline stall for the whole access, so the align
    // unit can decode straight from the EX/MEM buffer in every state.
    mem_load_align u_align (
        .aluop (ex_aluop),
        .addr  (ex_mem_addr[1:0]),
        .rdata (bus_rdata),
        .sel   (lane_sel),
        .data  (load_data)
    );

    always_comb begin
        state_d     = state_q;
        bus_stb_d   = bus_stb_q;
        bus_we_d    = bus_we_q;
        bus_sel_d   = bus_sel_q;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        data_d      = data_q;
        unique case (state_q)
            StIdle: begin
                if (mem_op) begin
                    bus_stb_d   = 1'b1;
                    bus_we_d    = store_op;
                    bus_sel_d   = lane_sel;
                    bus_addr_d  = {ex_mem_addr[31:2], 2'b00};
                    bus_wdata_d = store_data(ex_aluop, ex_reg2);
                    state_d     = StBusy;
                end
            end
            StBusy: begin
                if (bus_ack) begin
                    bus_stb_d = 1'b0;
                    data_d    = store_op ? bus_rdata : load_data;
                    state_d   = StDone;
                end
            end
            StDone: begin
                if (!stall[4]) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StIdle;
            bus_stb_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_sel_q   <= 4'b0000;
            bus_addr_q  <= ZeroWord;
            bus_wdata_q <= ZeroWord;
            data_q      <= ZeroWord;
        end else begin
            state_q     <= state_d;
            bus_stb_q   <= bus_stb_d;
            bus_we_q    <= bus_we_d;
            bus_sel_q   <= bus_sel_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
            data_q      <= data_d;
        end
    end

    always_comb begin
        mem_wd    = ex_wd;
        mem_wreg  = ex_wreg;
        mem_wdata = ex_wdata;
        mem_whilo = ex_whilo;
        mem_hi    = ex_hi;
        mem_lo    = ex_lo;
        stallreq  = 1'b0;
        if (!rst) begin
            mem_wd    = NOPRegAddr;
            mem_wreg  = WriteDisable;
            mem_wdata = ZeroWord;
            mem_whilo = WriteDisable;
            mem_hi    = ZeroWord;
            mem_lo    = ZeroWord;
        end else begin
            unique case (state_q)
                StIdle: stallreq = mem_op;
                StBusy: stallreq = 1'b1;
                StDone: if (load_op) mem_wdata = data_q;
                default: ;
            endcase
        end
    end

    assign bus_stb   = bus_stb_q;
    assign bus_we    = bus_we_q;
    assign bus_sel   = bus_sel_q;
    assign bus_addr  = bus_addr_q;
    assign bus_wdata = bus_wdata_q;

endmodule

// File: tb/tb_mem_access.sv
// Bench for mem_access: directed scenarios plus randomized loads/stores against an
// arithmetic reference model of lane selection, extraction and store replication.
module tb_mem_access;
    import mem_access_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [4:0]  ex_wd = 5'd0;
    logic        ex_wreg = 1'b0;
    logic [31:0] ex_wdata = 32'h0;
    logic        ex_whilo = 1'b0;
    logic [31:0] ex_hi = 32'h0;
    logic [31:0] ex_lo = 32'h0;
    logic [7:0]  ex_aluop = 8'h00;
    logic [31:0] ex_mem_addr = 32'h0;
    logic [31:0] ex_reg2 = 32'h0;
    logic [5:0]  stall = 6'b0;
    logic        bus_ack = 1'b0;
    logic [31:0] bus_rdata = 32'h0;
    logic [4:0]  mem_wd;
    logic        mem_wreg;
    logic [31:0] mem_wdata;
    logic        mem_whilo;
    logic [31:0] mem_hi;
    logic [31:0] mem_lo;
    logic        stallreq;
    logic        bus_stb;
    logic        bus_we;
    logic [3:0]  bus_sel;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;

    int checks = 0;
    int errors = 0;
    logic [7:0] mem_ops [8];

    always #5 clk = ~clk;

    mem_access dut (
        .clk(clk), .rst(rst),
        .ex_wd(ex_wd), .ex_wreg(ex_wreg), .ex_wdata(ex_wdata), .ex_whilo(ex_whilo),
        .ex_hi(ex_hi), .ex_lo(ex_lo), .ex_aluop(ex_aluop), .ex_mem_addr(ex_mem_addr),
        .ex_reg2(ex_reg2), .stall(stall), .bus_ack(bus_ack), .bus_rdata(bus_rdata),
        .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata), .mem_whilo(mem_whilo),
        .mem_hi(mem_hi), .mem_lo(mem_lo), .stallreq(stallreq), .bus_stb(bus_stb),
        .bus_we(bus_we), .bus_sel(bus_sel), .bus_addr(bus_addr), .bus_wdata(bus_wdata)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference model: access width in bytes, first byte index counted from the MSB.
    function automatic int op_bytes(input logic [7:0] op);
        if (op == OpLb || op == OpLbu || op == OpSb) return 1;
        if (op == OpLh || op == OpLhu || op == OpSh) return 2;
        return 4;
    endfunction

    function automatic bit op_is_store(input logic [7:0] op);
        return (op == OpSb || op == OpSh || op == OpSw);
    endfunction

    function automatic int first_byte(input logic [7:0] op, input logic [1:0] a);
        int n = op_bytes(op);
        return (int'(a) / n) * n;
    endfunction

    function automatic logic [3:0] ref_sel(input logic [7:0] op, input logic [1:0] a);
        int n = op_bytes(op);
        logic [3:0] m = (n == 1) ? 4'b1000 : (n == 2) ? 4'b1100 : 4'b1111;
        return m >> first_byte(op, a);
    endfunction

    function automatic logic [31:0] ref_load(input logic [7:0] op, input logic [1:0] a,
                                             input logic [31:0] rd);
        int n = op_bytes(op);
        int f = first_byte(op, a);
        logic [31:0] mask = (n == 4) ? 32'hFFFF_FFFF : ((32'd1 << (n * 8)) - 32'd1);
        logic [31:0] v = (rd >> ((4 - f - n) * 8)) & mask;
        if ((op == OpLb || op == OpLh) && v[n * 8 - 1]) v = v | ~mask;
        return v;
    endfunction

    function automatic logic [31:0] ref_wdata(input logic [7:0] op, input logic [31:0] r);
        int n = op_bytes(op);
        if (n == 1) return r[7:0] * 32'h0101_0101;
        if (n == 2) return r[15:0] * 32'h0001_0001;
        return r;
    endfunction

    task automatic run_access(input string tag, input logic [7:0] op, input logic [31:0] addr,
                              input logic [31:0] reg2, input logic [31:0] rdata,
                              input int ack_dly, input int nstall);
        int hi = 0;
        bit st = op_is_store(op);
        logic [31:0] exp_rd = ref_load(op, addr[1:0], rdata);
        @(negedge clk);
        ex_aluop = op; ex_mem_addr = addr; ex_reg2 = reg2;
        ex_wd = 5'($urandom); ex_wreg = st ? 1'b0 : 1'b1; ex_wdata = $urandom;
        ex_whilo = 1'b0; stall = 6'b0; bus_ack = 1'b0;
        #1;
        if (stallreq) hi++;
        chk({tag, " stb_idle"}, bus_stb, 0);
        @(posedge clk); #1;
        chk({tag, " stb_issue"}, bus_stb, 1);
        chk({tag, " addr"}, bus_addr, addr & ~32'h3);
        chk({tag, " sel"}, bus_sel, ref_sel(op, addr[1:0]));
        chk({tag, " we"}, bus_we, st);
        if (st) chk({tag, " wdata"}, bus_wdata, ref_wdata(op, reg2));
        for (int i = 1; i <= ack_dly; i++) begin
            @(negedge clk);
            if (i == ack_dly) begin bus_ack = 1'b1; bus_rdata = rdata; end
            #1;
            if (stallreq) hi++;
            chk({tag, " stb_hold"}, bus_stb, 1);
            chk({tag, " addr_hold"}, bus_addr, addr & ~32'h3);
        end
        @(posedge clk); #1;
        bus_ack = 1'b0; bus_rdata = ~rdata;
        chk({tag, " stall_cycles"}, hi, ack_dly + 1);
        chk({tag, " stb_done"}, bus_stb, 0);
        chk({tag, " stallreq_done"}, stallreq, 0);
        chk({tag, " wd"}, mem_wd, ex_wd);
        chk({tag, " wreg"}, mem_wreg, ex_wreg);
        chk({tag, " wdata_done"}, mem_wdata, st ? ex_wdata : exp_rd);
        if (nstall > 0) begin
            stall = 6'b01_0000;
            for (int i = 0; i < nstall; i++) begin
                if (i == 0) bus_ack = 1'b1;
                @(posedge clk); #1;
                bus_ack = 1'b0;
                chk({tag, " held_stallreq"}, stallreq, 0);
                chk({tag, " held_wdata"}, mem_wdata, st ? ex_wdata : exp_rd);
                chk({tag, " held_stb"}, bus_stb, 0);
            end
            stall = 6'b0;
        end
        @(posedge clk); #1;
        // Back in IDLE with the op still presented: a new request shows immediately.
        chk({tag, " idle_again"}, stallreq, 1);
        chk({tag, " idle_wdata"}, mem_wdata, ex_wdata);
        ex_aluop = 8'h25;
        #1;
        chk({tag, " nop_stallreq"}, stallreq, 0);
        @(posedge clk); #1;
        chk({tag, " nop_stb"}, bus_stb, 0);
    endtask

    initial begin
        mem_ops = '{OpLb, OpLbu, OpLh, OpLhu, OpLw, OpSb, OpSh, OpSw};

        // Reset values with live-looking inputs.
        ex_wd = 5'd9; ex_wreg = 1'b1; ex_wdata = 32'hDEAD_BEEF; ex_whilo = 1'b1;
        ex_hi = 32'h1111_1111; ex_lo = 32'h2222_2222; ex_aluop = OpLw;
        #2;
        chk("rst_stallreq", stallreq, 0);
        chk("rst_wd", mem_wd, NOPRegAddr);
        chk("rst_wreg", mem_wreg, WriteDisable);
        chk("rst_whilo", mem_whilo, WriteDisable);
        chk("rst_wdata", mem_wdata, 32'h0);
        chk("rst_hi", mem_hi, 32'h0);
        chk("rst_stb", bus_stb, 0);
        chk("rst_sel", bus_sel, 0);
        @(negedge clk);
        ex_aluop = 8'h25;
        rst = 1'b1;

        // Non-memory pass-through, including a stray ack in IDLE.
        @(negedge clk);
        ex_wdata = 32'h1234_5678; ex_wd = 5'd5; ex_wreg = 1'b1;
        ex_whilo = 1'b1; ex_hi = 32'hAAAA_0001; ex_lo = 32'h5555_0002;
        #1;
        chk("nop_wdata", mem_wdata, 32'h1234_5678);
        chk("nop_wd", mem_wd, 5'd5);
        chk("nop_wreg", mem_wreg, 1);
        chk("nop_whilo", mem_whilo, 1);
        chk("nop_hi", mem_hi, 32'hAAAA_0001);
        chk("nop_lo", mem_lo, 32'h5555_0002);
        chk("nop_stallreq", stallreq, 0);
        for (int i = 0; i < 3; i++) begin
            bus_ack = (i == 1);
            @(posedge clk); #1;
            chk("nop_stb", bus_stb, 0);
            chk("nop_stallreq_run", stallreq, 0);
        end
        bus_ack = 1'b0;

        // Directed loads/stores.
        run_access("lb", OpLb, 32'h0000_0103, 32'h0, 32'h0000_0080, 3, 0);
        run_access("lbu", OpLbu, 32'h0000_0103, 32'h0, 32'h0000_0080, 3, 0);
        run_access("sh", OpSh, 32'h0000_0202, 32'hABCD_BEEF, 32'h0, 2, 0);
        chk("sh_wdata_abs", bus_wdata, 32'hBEEF_BEEF);
        chk("sh_sel_abs", bus_sel, 4'b0011);
        run_access("lw_stall", OpLw, 32'h0000_0400, 32'h0, 32'hCAFE_F00D, 1, 2);
        run_access("lh_mis", OpLh, 32'h0000_0011, 32'h0, 32'h8001_7FFE, 1, 1);

        // Reset asserted in the middle of an access, followed by a late ack.
        @(negedge clk);
        ex_aluop = OpLw; ex_mem_addr = 32'h0000_0300; ex_wd = 5'd7; ex_wreg = 1'b1;
        ex_wdata = 32'h0BAD_F00D;
        @(posedge clk); #1;
        chk("rb_stb", bus_stb, 1);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rb_stb_drop", bus_stb, 0);
        chk("rb_stallreq", stallreq, 0);
        chk("rb_wd", mem_wd, NOPRegAddr);
        chk("rb_wdata", mem_wdata, 32'h0);
        chk("rb_addr", bus_addr, 32'h0);
        chk("rb_sel", bus_sel, 0);
        @(negedge clk);
        rst = 1'b1; ex_aluop = 8'h25; bus_ack = 1'b1; bus_rdata = 32'h7777_7777;
        #1;
        chk("rb_idle_stallreq", stallreq, 0);
        chk("rb_idle_wdata", mem_wdata, 32'h0BAD_F00D);
        @(posedge clk); #1;
        bus_ack = 1'b0;
        chk("rb_late_ack_stb", bus_stb, 0);
        chk("rb_late_ack_stallreq", stallreq, 0);
        chk("rb_late_ack_addr", bus_addr, 32'h0);

        // Randomized accesses.
        for (int i = 0; i < 20; i++) begin
            run_access($sformatf("rnd%0d", i), mem_ops[$urandom_range(0, 7)], $urandom,
                       $urandom, $urandom, int'($urandom_range(1, 4)),
                       int'($urandom_range(0, 2)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
